// File: rtl/sdm_audio_pkg.sv
// Shared defaults and helpers for the 1-bit sigma-delta audio path.
// The sddac input width and the PDM decimator are both built from these.
package sdm_audio_pkg;

  localparam int CIC_N_DEF     = 3;
  localparam int DEC_R_DEF     = 1000;
  localparam int ACC_W_DEF     = 32;
  localparam int OUT_W_DEF     = 16;
  localparam int OUT_SHIFT_DEF = 15;

  typedef logic signed [OUT_W_DEF-1:0] pcm_sample_t;

  // Register growth of an N-stage CIC is N*log2(R) bits, plus sign and input bit.
  function automatic int minAccW(input int cicN, input int decR);
    return cicN * $clog2(decR) + 2;
  endfunction

endpackage

// File: rtl/pdm_cic_decimator_if.sv
// PDM bit stream in, decimated PCM samples out.
// The master drives the bit stream; the decimator is the slave.
interface pdm_cic_decimator_if
  import sdm_audio_pkg::*;
#(
  parameter int OUT_W = OUT_W_DEF
);

  logic                    ce;
  logic                    pdm_in;
  logic signed [OUT_W-1:0] pcm_out;
  logic                    pcm_valid;
  logic                    sat_flag;

  modport master (
    output ce,
    output pdm_in,
    input  pcm_out,
    input  pcm_valid,
    input  sat_flag
  );

  modport slave (
    input  ce,
    input  pdm_in,
    output pcm_out,
    output pcm_valid,
    output sat_flag
  );

endinterface

// File: rtl/cic_comb_stage.sv
// One CIC differentiator: y = x - x_prev, where x_prev advances only on valid samples.
module cic_comb_stage #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_data,
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_data
);

  logic signed [WIDTH-1:0] r_prev;
  logic signed [WIDTH-1:0] r_data;
  logic                    r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data - r_prev;
        r_prev <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pdm_cic_decimator.sv
// N-stage CIC decimator turning a 1-bit PDM stream into saturated signed PCM.
// Integrators run on ce-qualified bits; the comb chain runs one stage per clock.
module pdm_cic_decimator
  import sdm_audio_pkg::*;
#(
  parameter int CIC_N     = CIC_N_DEF,
  parameter int DEC_R     = DEC_R_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
  input logic                 clk,
  input logic                 rst,
  pdm_cic_decimator_if.slave  bus
);

  localparam int CNT_W = $clog2(DEC_R);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_R - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  if (CIC_N < 1 || CIC_N > 5) begin : g_badCicN
    $error("pdm_cic_decimator: CIC_N must be in 1..5");
  end
  if (DEC_R < CIC_N + 2) begin : g_badDecR
    $error("pdm_cic_decimator: DEC_R must be at least CIC_N+2 so samples never overlap");
  end
  if (ACC_W < minAccW(CIC_N, DEC_R)) begin : g_badAccW
    $error("pdm_cic_decimator: ACC_W too narrow for CIC_N and DEC_R");
  end

  logic [1:0]              r_rstSync;
  logic                    w_rstInt;
  logic signed [ACC_W-1:0] w_x;
  logic signed [ACC_W-1:0] r_integ     [CIC_N];
  logic signed [ACC_W-1:0] w_integNext [CIC_N];
  logic [CNT_W-1:0]        r_decCount;
  logic signed [ACC_W-1:0] r_decSample;
  logic                    r_decValid;
  logic signed [ACC_W-1:0] w_combData  [CIC_N+1];
  logic [CIC_N:0]          w_combValid;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [OUT_W-1:0] w_pcm;
  logic                    w_sat;
  logic signed [OUT_W-1:0] r_pcm;
  logic                    r_pcmValid;
  logic                    r_sat;

  // Reset asserts at once but releases on a clock edge, so no stage leaves reset a cycle early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstSync <= 2'b11;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b0};
    end
  end

  assign w_rstInt = r_rstSync[1];
  assign w_x      = {{(ACC_W-1){~bus.pdm_in}}, 1'b1};

  always_comb begin
    w_integNext[0] = r_integ[0] + w_x;
    for (int k = 1; k < CIC_N; k++) begin
      w_integNext[k] = r_integ[k] + r_integ[k-1];
    end
  end

  always_ff @(posedge clk or posedge w_rstInt) begin
    if (w_rstInt) begin
      for (int k = 0; k < CIC_N; k++) begin
        r_integ[k] <= '0;
      end
    end else if (bus.ce) begin
      for (int k = 0; k < CIC_N; k++) begin
        r_integ[k] <= w_integNext[k];
      end
    end
  end

  // The latched sample includes this cycle's integrator update; wrap-around is intended.
  always_ff @(posedge clk or posedge w_rstInt) begin
    if (w_rstInt) begin
      r_decCount  <= '0;
      r_decSample <= '0;
      r_decValid  <= 1'b0;
    end else begin
      r_decValid <= 1'b0;
      if (bus.ce) begin
        if (r_decCount == CNT_LAST) begin
          r_decCount  <= '0;
          r_decSample <= w_integNext[CIC_N-1];
          r_decValid  <= 1'b1;
        end else begin
          r_decCount <= r_decCount + CNT_W'(1);
        end
      end
    end
  end

  assign w_combData[0]  = r_decSample;
  assign w_combValid[0] = r_decValid;

  for (genvar g = 0; g < CIC_N; g++) begin : g_comb
    cic_comb_stage #(
      .WIDTH (ACC_W)
    ) u_stage (
      .clk     (clk),
      .rst     (w_rstInt),
      .i_valid (w_combValid[g]),
      .i_data  (w_combData[g]),
      .o_valid (w_combValid[g+1]),
      .o_data  (w_combData[g+1])
    );
  end

  assign w_shifted = w_combData[CIC_N] >>> OUT_SHIFT;

  always_comb begin
    w_pcm = w_shifted[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_shifted > SAT_HI) begin
      w_pcm = SAT_HI[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_shifted < SAT_LO) begin
      w_pcm = SAT_LO[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge w_rstInt) begin
    if (w_rstInt) begin
      r_pcm      <= '0;
      r_pcmValid <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_pcmValid <= w_combValid[CIC_N];
      r_sat      <= 1'b0;
      if (w_combValid[CIC_N]) begin
        r_pcm <= w_pcm;
        r_sat <= w_sat;
      end
    end
  end

  assign bus.pcm_out   = r_pcm;
  assign bus.pcm_valid = r_pcmValid;
  assign bus.sat_flag  = r_sat;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator: two instances (shift 15 and shift 13) see the same stream.
// Expected sample timing comes from the bench's own ce count, values from hand-computed constants.
module tb_pdm_cic_decimator;
  import sdm_audio_pkg::*;

  localparam int CLK_HALF = 10;
  localparam int N        = CIC_N_DEF;
  localparam int R        = DEC_R_DEF;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int compareCount  = 0;
  int mismatchCount = 0;
  int stepIdx       = 0;
  int ceCount       = 0;
  int sampleNum     = 0;
  int validCount    = 0;
  int lastValidStep = -1;
  int dueQ[$];
  int expMain, expSatMain, expShift, expSatShift, expPeriod;

  pdm_cic_decimator_if #(.OUT_W(OUT_W_DEF)) busMain ();
  pdm_cic_decimator_if #(.OUT_W(OUT_W_DEF)) busShift ();

  pdm_cic_decimator #(.OUT_SHIFT(15)) dutMain  (.clk(clk), .rst(rst), .bus(busMain));
  pdm_cic_decimator #(.OUT_SHIFT(13)) dutShift (.clk(clk), .rst(rst), .bus(busShift));

  always #CLK_HALF clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed != expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic setExpect(input int eMain, input int sMain, input int eShift, input int sShift,
                           input int period);
    expMain     = eMain;
    expSatMain  = sMain;
    expShift    = eShift;
    expSatShift = sShift;
    expPeriod   = period;
  endtask

  task automatic driveInputs(input logic ceVal, input logic bitVal);
    busMain.ce      = ceVal;
    busMain.pdm_in  = bitVal;
    busShift.ce     = ceVal;
    busShift.pdm_in = bitVal;
  endtask

  task automatic observe();
    if (busMain.pcm_valid) begin
      validCount++;
      sampleNum++;
      if (dueQ.size() == 0) begin
        checkOutput("strayValid", 1, 0);
      end else begin
        checkOutput("latency", stepIdx, dueQ[0]);
        void'(dueQ.pop_front());
      end
      checkOutput("validShift", int'(busShift.pcm_valid), 1);
      if (lastValidStep >= 0) checkOutput("period", stepIdx - lastValidStep, expPeriod);
      lastValidStep = stepIdx;
      if (sampleNum > N) begin
        checkOutput("pcmMain", int'(busMain.pcm_out), expMain);
        checkOutput("satMain", int'(busMain.sat_flag), expSatMain);
        checkOutput("pcmShift", int'(busShift.pcm_out), expShift);
        checkOutput("satShift", int'(busShift.sat_flag), expSatShift);
      end
    end else begin
      if (dueQ.size() > 0 && dueQ[0] <= stepIdx) begin
        checkOutput("missingValid", 0, 1);
        void'(dueQ.pop_front());
      end
      if (busMain.sat_flag) checkOutput("satWithoutValid", 1, 0);
    end
  endtask

  // Inputs change at the falling edge, are consumed on the next rising edge, outputs seen at the next fall.
  task automatic stepCycle(input logic ceVal, input logic bitVal);
    driveInputs(ceVal, bitVal);
    if (ceVal) begin
      ceCount++;
      if (ceCount % R == 0) dueQ.push_back(stepIdx + N + 1);
    end
    @(negedge clk);
    observe();
    stepIdx++;
  endtask

  task automatic doReset(input string tag);
    driveInputs(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput({tag, "_pcmMain"}, int'(busMain.pcm_out), 0);
    checkOutput({tag, "_validMain"}, int'(busMain.pcm_valid), 0);
    checkOutput({tag, "_satMain"}, int'(busMain.sat_flag), 0);
    checkOutput({tag, "_pcmShift"}, int'(busShift.pcm_out), 0);
    #47 rst = 1'b0;
    @(negedge clk);
    dueQ.delete();
    ceCount       = 0;
    sampleNum     = 0;
    validCount    = 0;
    lastValidStep = -1;
    for (int i = 0; i < 3; i++) stepCycle(1'b0, 1'b0);
  endtask

  // mode 0: all ones, 1: all zeros, 2: alternating 1,0 on consumed bits.
  task automatic applyStimulus(input int mode, input int ceEvery, input int numSamples,
                               input int extraCe, input bit flush);
    int   total;
    logic ceVal;
    logic bitVal;
    total = (numSamples * R + extraCe) * ceEvery;
    for (int i = 0; i < total; i++) begin
      ceVal = ((i % ceEvery) == (ceEvery - 1));
      case (mode)
        0:       bitVal = 1'b1;
        1:       bitVal = 1'b0;
        default: bitVal = ((ceCount % 2) == 0);
      endcase
      stepCycle(ceVal, bitVal);
    end
    if (flush) begin
      for (int i = 0; i < N + 5; i++) stepCycle(1'b0, 1'b0);
    end
  endtask

  initial begin
    driveInputs(1'b0, 1'b0);
    setExpect(0, 0, 0, 0, R);
    doReset("initReset");

    $display("[TB] all ones, ce every clock");
    setExpect(30517, 0, 32767, 1, R);
    applyStimulus(0, 1, 6, 0, 1'b1);
    checkOutput("countOnes", validCount, 6);

    $display("[TB] all zeros, ce every clock");
    doReset("resetZeros");
    setExpect(-30518, 0, -32768, 1, R);
    applyStimulus(1, 1, 6, 0, 1'b1);
    checkOutput("countZeros", validCount, 6);

    $display("[TB] alternating bits");
    doReset("resetAlt");
    setExpect(0, 0, 0, 0, R);
    applyStimulus(2, 1, 6, 0, 1'b1);
    checkOutput("countAlt", validCount, 6);

    $display("[TB] all ones, ce one clock in four");
    doReset("resetDuty");
    setExpect(30517, 0, 32767, 1, 4 * R);
    applyStimulus(0, 4, 5, 0, 1'b1);
    checkOutput("countDuty", validCount, 5);

    $display("[TB] reset pulse 400 bits into a sample");
    doReset("resetPre");
    setExpect(30517, 0, 32767, 1, R);
    applyStimulus(0, 1, 5, 400, 1'b0);
    checkOutput("countBeforeReset", validCount, 5);
    doReset("midReset");
    applyStimulus(0, 1, 1, 0, 1'b1);
    checkOutput("countAfterReset", validCount, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
